// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter that shares one 8-bit valid/ready UART
//               transmit byte channel between NUM_REQ requesters. A grant is
//               held for a whole message (until req_last) or until MAX_BURST
//               bytes have been forwarded, so messages never interleave.
//               There is one idle bubble cycle between consecutive grants.
//
// Parameters  : NUM_REQ   - number of requesters (2..8)
//               MAX_BURST - byte cap per grant (1..255)
//
// Ports       : clk        in   clock
//               reset      in   synchronous, active-high reset
//               req_valid  in   [NUM_REQ]   per-requester byte valid
//               req_data   in   [8*NUM_REQ] requester i on bits [8i+7:8i]
//               req_last   in   [NUM_REQ]   final byte of requester i message
//               req_ready  out  [NUM_REQ]   per-requester byte accepted
//               out_valid  out  byte valid to UART (tx_data_valid)
//               out_data   out  [8] byte to UART (tx_data)
//               out_ready  in   UART ready (tx_data_ready)
//               grant_id   out  [$clog2(NUM_REQ)] current / most recent grant
//               busy       out  high while a grant is active
//
// Build option: UART_ARB_ID_HEADER_EN - when defined, every grant first sends
//               a header byte 8'hA0 | grant_id before the requester's bytes.
//               The header byte does not count toward MAX_BURST.
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int               c_GW        = $clog2(NUM_REQ);
    localparam logic [c_GW:0]    c_NUM_EXT   = (c_GW+1)'(NUM_REQ);
    localparam logic [7:0]       c_MAX_BURST = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_HEADER = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [c_GW-1:0]   grant_q, grant_d;
    logic [c_GW-1:0]   rr_q,    rr_d;
    logic [7:0]        burst_q, burst_d;

    logic              w_sel_found;
    logic [c_GW-1:0]   w_sel_idx;
    logic [c_GW:0]     w_sum;
    logic [c_GW-1:0]   w_idx;
    logic [7:0]        w_burst_inc;
    logic              w_xfer;

    // ------------------------------------------------------------------------
    // Round-robin selection: scan rr_q+1, rr_q+2, ... wrapping modulo NUM_REQ.
    // The scan ends at rr_q itself, so the last-served requester has the
    // lowest priority. The sum is one bit wider so the wrap works for
    // non-power-of-two NUM_REQ.
    // ------------------------------------------------------------------------
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, rr_q} + (c_GW+1)'(k);
            if (w_sum >= c_NUM_EXT) begin
                w_sum = w_sum - c_NUM_EXT;
            end
            w_idx = w_sum[c_GW-1:0];
            if (!w_sel_found && req_valid[w_idx]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_idx;
            end
        end
    end

    assign w_burst_inc = burst_q + 8'd1;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= c_GW'(NUM_REQ - 1);
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        burst_d   = burst_q;
        out_valid = 1'b0;
        out_data  = 8'h00;
        req_ready = '0;
        busy      = 1'b0;
        w_xfer    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_sel_found) begin
                    grant_d = w_sel_idx;
                    burst_d = '0;
`ifdef UART_ARB_ID_HEADER_EN
                    state_d = S_HEADER;
`else
                    state_d = S_STREAM;
`endif
                end
            end

            S_STREAM: begin
                busy               = 1'b1;
                // Straight pass-through: the requester holds its byte while
                // out_ready is low, so out_data stays stable during a stall.
                out_valid          = req_valid[grant_q];
                out_data           = req_data[{grant_q, 3'b000} +: 8];
                req_ready[grant_q] = out_ready;
                w_xfer             = out_valid && out_ready && !reset;
                if (w_xfer) begin
                    burst_d = (burst_q == c_MAX_BURST) ? burst_q : w_burst_inc;
                    if (req_last[grant_q] || (w_burst_inc == c_MAX_BURST)) begin
                        rr_d    = grant_q;
                        state_d = S_IDLE;
                    end
                end
            end

`ifdef UART_ARB_ID_HEADER_EN
            S_HEADER: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = 8'hA0 | 8'(grant_q);
                if (out_ready) begin
                    state_d = S_STREAM;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // No byte may be handed over on a reset cycle, even mid-message.
        if (reset) begin
            out_valid = 1'b0;
            req_ready = '0;
        end
    end

    assign grant_id = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4,
//               MAX_BURST=16). Each requester is a simple byte source that
//               emits base+index and advances on its own handshake. Inputs
//               change 1 ns after the rising edge; outputs are sampled on the
//               falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b1;
    logic [1:0]  grant_id;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Source model
    int         src_len  [4];
    int         src_idx  [4];
    logic [7:0] src_base [4];
    bit         src_on   [4];
    bit         src_last [4];
    logic [3:0] acc = '0;

    // Stimulus controls
    bit rst_cmd  = 1'b1;
    int rdy_mode = 0;
    int cyc      = 0;

    // Transfer log
    logic [7:0] log_data [$];
    logic [1:0] log_gid  [$];
    int         log_cyc  [$];

    uart_tx_arbiter #(
        .NUM_REQ   (4),
        .MAX_BURST (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_src();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = src_on[i] && (src_idx[i] < src_len[i]);
            req_data[8*i +: 8] = src_base[i] + 8'(src_idx[i]);
            req_last[i]        = src_last[i] && (src_idx[i] == src_len[i] - 1);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            src_on[i]   = 1'b0;
            src_idx[i]  = 0;
            src_len[i]  = 0;
            src_base[i] = 8'h00;
            src_last[i] = 1'b0;
        end
        log_data.delete();
        log_gid.delete();
        log_cyc.delete();
    endtask

    task automatic set_src(input int i, input int len, input logic [7:0] base, input bit last);
        src_on[i]   = 1'b1;
        src_idx[i]  = 0;
        src_len[i]  = len;
        src_base[i] = base;
        src_last[i] = last;
    endtask

    // One clock: apply inputs after the rising edge, sample on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        reset = rst_cmd;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) src_idx[i]++;
        end
        drive_src();
        out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4) == 3);
        @(negedge clk);
        cyc++;
        acc = '0;
        if (out_valid && out_ready) begin
            log_data.push_back(out_data);
            log_gid.push_back(grant_id);
            log_cyc.push_back(cyc);
            acc = req_valid & req_ready;
        end
    endtask

    task automatic do_reset(input int n);
        rst_cmd = 1'b1;
        repeat (n) step();
        rst_cmd = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        clear_src();
        rdy_mode = 0;
        do_reset(2);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b out_valid=%b req_ready=%b grant_id=%0d, want 0 0 0000 0",
                     busy, out_valid, req_ready, grant_id);
        end
    endtask

    task automatic test_single();
        set_src(0, 1, 8'h55, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_latency: out_valid=%b in arbitration cycle, want 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h55 || grant_id !== 2'd0 || busy !== 1'b1 || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_stream: valid=%b data=%h gid=%0d busy=%b rdy=%b, want 1 55 0 1 0001",
                     out_valid, out_data, grant_id, busy, req_ready);
        end
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || log_data.size() != 1) begin
            failures++;
            $display("FAIL single_release: busy=%b out_valid=%b transfers=%0d, want 0 0 1",
                     busy, out_valid, log_data.size());
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [8] = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41, 8'h50, 8'h51};
        clear_src();
        do_reset(1);
        set_src(0, 2, 8'h20, 1'b1);
        set_src(1, 2, 8'h30, 1'b1);
        set_src(2, 2, 8'h40, 1'b1);
        set_src(3, 2, 8'h50, 1'b1);
        for (int k = 0; k < 40 && log_data.size() < 8; k++) step();
        checks++;
        if (log_data.size() < 8) begin
            failures++;
            $display("FAIL rr_timeout: transfers=%0d, want 8", log_data.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (log_data[j] !== exp_d[j] || log_gid[j] !== 2'(j / 2)) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: data=%h gid=%0d, want %h %0d",
                             j, log_data[j], log_gid[j], exp_d[j], j / 2);
                end
            end
            for (int j = 1; j < 8; j++) begin
                checks++;
                if ((log_cyc[j] - log_cyc[j-1]) != ((j % 2 == 0) ? 2 : 1)) begin
                    failures++;
                    $display("FAIL rr_gap[%0d]: gap=%0d, want %0d",
                             j, log_cyc[j] - log_cyc[j-1], (j % 2 == 0) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_max_burst();
        clear_src();
        do_reset(1);
        set_src(2, 20, 8'h60, 1'b0);
        step();
        set_src(1, 2, 8'h90, 1'b1);
        for (int k = 0; k < 60 && log_data.size() < 18; k++) step();
        checks++;
        if (log_data.size() < 18) begin
            failures++;
            $display("FAIL burst_timeout: transfers=%0d, want 18", log_data.size());
        end else begin
            for (int j = 0; j < 16; j++) begin
                checks++;
                if (log_data[j] !== 8'h60 + 8'(j) || log_gid[j] !== 2'd2) begin
                    failures++;
                    $display("FAIL burst_req2[%0d]: data=%h gid=%0d, want %h 2",
                             j, log_data[j], log_gid[j], 8'h60 + 8'(j));
                end
            end
            checks++;
            if (log_data[16] !== 8'h90 || log_gid[16] !== 2'd1 || log_data[17] !== 8'h91 || log_gid[17] !== 2'd1) begin
                failures++;
                $display("FAIL burst_next_grant: data=%h,%h gid=%0d,%0d, want 90,91 1,1",
                         log_data[16], log_data[17], log_gid[16], log_gid[17]);
            end
            checks++;
            if ((log_cyc[16] - log_cyc[15]) != 2) begin
                failures++;
                $display("FAIL burst_bubble: gap=%0d, want 2", log_cyc[16] - log_cyc[15]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_src();
        do_reset(1);
        rdy_mode = 1;
        set_src(3, 4, 8'h10, 1'b1);
        for (int k = 0; k < 40 && log_data.size() < 4; k++) begin
            step();
            if (out_valid) begin
                checks++;
                if (out_data !== 8'h10 + 8'(src_idx[3]) || grant_id !== 2'd3) begin
                    failures++;
                    $display("FAIL bp_data: data=%h gid=%0d, want %h 3",
                             out_data, grant_id, 8'h10 + 8'(src_idx[3]));
                end
            end
            if (busy) begin
                checks++;
                if (req_ready !== (out_ready ? 4'b1000 : 4'b0000)) begin
                    failures++;
                    $display("FAIL bp_ready: req_ready=%b out_ready=%b, want %b",
                             req_ready, out_ready, out_ready ? 4'b1000 : 4'b0000);
                end
            end
        end
        checks++;
        if (log_data.size() != 4 || log_data[0] !== 8'h10 || log_data[3] !== 8'h13) begin
            failures++;
            $display("FAIL bp_count: transfers=%0d, want 4 (10..13)", log_data.size());
        end
        rdy_mode = 0;
    endtask

    task automatic test_reset_mid();
        clear_src();
        do_reset(1);
        set_src(0, 1, 8'hC0, 1'b1);
        set_src(1, 5, 8'hB0, 1'b1);
        for (int k = 0; k < 30 && log_data.size() < 4; k++) step();
        checks++;
        if (log_data.size() != 4 || log_data[0] !== 8'hC0 || log_data[1] !== 8'hB0 || log_gid[1] !== 2'd1) begin
            failures++;
            $display("FAIL mid_prefix: transfers=%0d, want 4 starting C0,B0", log_data.size());
        end
        rst_cmd = 1'b1;
        step();
        for (int i = 0; i < 4; i++) src_on[i] = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || log_data.size() != 4) begin
            failures++;
            $display("FAIL mid_reset_cycle: out_valid=%b transfers=%0d, want 0 4", out_valid, log_data.size());
        end
        rst_cmd = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || src_idx[1] != 3) begin
            failures++;
            $display("FAIL mid_after_reset: busy=%b out_valid=%b req1_bytes=%0d, want 0 0 3",
                     busy, out_valid, src_idx[1]);
        end
        clear_src();
        set_src(0, 1, 8'hD0, 1'b1);
        set_src(1, 1, 8'hD1, 1'b1);
        for (int k = 0; k < 20 && log_data.size() < 2; k++) step();
        checks++;
        if (log_data.size() != 2 || log_gid[0] !== 2'd0 || log_data[0] !== 8'hD0 ||
            log_gid[1] !== 2'd1 || log_data[1] !== 8'hD1) begin
            failures++;
            $display("FAIL mid_rr_restart: transfers=%0d, want gid0 D0 then gid1 D1", log_data.size());
        end
    endtask

`ifdef UART_ARB_ID_HEADER_EN
    task automatic test_header();
        clear_src();
        do_reset(1);
        set_src(2, 1, 8'h33, 1'b1);
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA2 || req_ready !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL hdr_state: valid=%b data=%h rdy=%b busy=%b, want 1 A2 0000 1",
                     out_valid, out_data, req_ready, busy);
        end
        for (int k = 0; k < 10 && log_data.size() < 2; k++) step();
        checks++;
        if (log_data.size() != 2 || log_data[0] !== 8'hA2 || log_data[1] !== 8'h33) begin
            failures++;
            $display("FAIL hdr_bytes: transfers=%0d, want A2 then 33", log_data.size());
        end
    endtask
`endif

    initial begin
        clear_src();
        test_reset();
        test_single();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_reset_mid();
`ifdef UART_ARB_ID_HEADER_EN
        test_header();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
